// File: rtl/slow_clock_monitor.sv
// Turns a slow, possibly asynchronous clock-like input into clk-domain edge ticks,
// measures its period between rising edges and flags it as stalled when it stops toggling.
module slow_clock_monitor #(
   parameter int unsigned SYNC_STAGES  = 2,
   parameter int unsigned PERIOD_WIDTH = 16,
   parameter int unsigned TIMEOUT      = 2000
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    slow_in,
   input  logic                    en,
   output logic                    level,
   output logic                    rise_tick,
   output logic                    fall_tick,
   output logic [PERIOD_WIDTH-1:0] period,
   output logic                    period_valid,
   output logic                    stalled,
   output logic [7:0]              edge_count
);

   localparam int unsigned TcntWidth = $clog2(TIMEOUT) + 1;
   localparam logic [TcntWidth-1:0]    TcntLast = TcntWidth'(TIMEOUT - 1);
   localparam logic [TcntWidth-1:0]    TcntMax  = '1;
   localparam logic [PERIOD_WIDTH-1:0] PcntMax  = '1;

   typedef enum logic [1:0] {StIdle, StMeasure, StStalled} state_e;

   state_e                  state_q, state_d;
   logic [SYNC_STAGES-1:0]  sync_q;
   logic                    prev_q;
   logic                    rise, fall;
   logic                    rise_tick_q, fall_tick_q;
   logic [PERIOD_WIDTH-1:0] pcnt_q, pcnt_d;
   logic [TcntWidth-1:0]    tcnt_q, tcnt_d;
   logic [PERIOD_WIDTH-1:0] period_q, period_d;
   logic                    period_valid_q, period_valid_d;
   logic                    stalled_q, stalled_d;
   logic [7:0]              edge_count_q, edge_count_d;

   // Synchroniser and prev run every cycle, so edges seen while en=0 are consumed, not replayed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], slow_in};
         prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign level = sync_q[SYNC_STAGES-1];
   assign rise  = en & level & ~prev_q;
   assign fall  = en & ~level & prev_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Edges take priority over the timeout, so a rise or fall on the last cycle prevents a stall.
   always_comb begin
      state_d = state_q;
      if (en) begin
         case (state_q)
            StIdle, StMeasure: begin
               if (rise) begin
                  state_d = StMeasure;
               end else if (!fall && (tcnt_q == TcntLast)) begin
                  state_d = StStalled;
               end
            end
            StStalled: begin
               if (rise) begin
                  state_d = StMeasure;
               end else if (fall) begin
                  state_d = StIdle;
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   always_comb begin
      pcnt_d         = pcnt_q;
      tcnt_d         = tcnt_q;
      period_d       = period_q;
      period_valid_d = 1'b0;
      edge_count_d   = edge_count_q;
      if (en) begin
         if (pcnt_q != PcntMax) begin
            pcnt_d = pcnt_q + 1'b1;
         end
         if (rise || fall) begin
            tcnt_d = '0;
         end else if (tcnt_q != TcntMax) begin
            tcnt_d = tcnt_q + 1'b1;
         end
         if (rise) begin
            pcnt_d       = '0;
            edge_count_d = edge_count_q + 8'd1;
            // Only a rise that closes a full period in MEASURE produces a measurement.
            if (state_q == StMeasure) begin
               period_d       = (pcnt_q == PcntMax) ? PcntMax : pcnt_q + 1'b1;
               period_valid_d = 1'b1;
            end
         end
      end
      stalled_d = (state_d == StStalled);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rise_tick_q    <= 1'b0;
         fall_tick_q    <= 1'b0;
         pcnt_q         <= '0;
         tcnt_q         <= '0;
         period_q       <= '0;
         period_valid_q <= 1'b0;
         stalled_q      <= 1'b0;
         edge_count_q   <= '0;
      end else begin
         rise_tick_q    <= rise;
         fall_tick_q    <= fall;
         pcnt_q         <= pcnt_d;
         tcnt_q         <= tcnt_d;
         period_q       <= period_d;
         period_valid_q <= period_valid_d;
         stalled_q      <= stalled_d;
         edge_count_q   <= edge_count_d;
      end
   end

   assign rise_tick    = rise_tick_q;
   assign fall_tick    = fall_tick_q;
   assign period       = period_q;
   assign period_valid = period_valid_q;
   assign stalled      = stalled_q;
   assign edge_count   = edge_count_q;

endmodule

// File: tb/tb_slow_clock_monitor.sv
// Drives two monitor instances (default and narrow/short-timeout) with shared random stimulus
// and compares every output each cycle against an event-level reference model.
module tb_slow_clock_monitor;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   logic slow_in = 1'b0;
   logic en = 1'b1;

   logic        lvl [2];
   logic        rtk [2];
   logic        ftk [2];
   logic        pvl [2];
   logic        stl [2];
   logic [7:0]  ecn [2];
   logic [15:0] per0;
   logic [3:0]  per1;

   always #5 clk = ~clk;

   slow_clock_monitor dut0 (
      .clk          (clk),
      .rst_n        (rst_n),
      .slow_in      (slow_in),
      .en           (en),
      .level        (lvl[0]),
      .rise_tick    (rtk[0]),
      .fall_tick    (ftk[0]),
      .period       (per0),
      .period_valid (pvl[0]),
      .stalled      (stl[0]),
      .edge_count   (ecn[0])
   );

   slow_clock_monitor #(
      .SYNC_STAGES  (3),
      .PERIOD_WIDTH (4),
      .TIMEOUT      (100)
   ) dut1 (
      .clk          (clk),
      .rst_n        (rst_n),
      .slow_in      (slow_in),
      .en           (en),
      .level        (lvl[1]),
      .rise_tick    (rtk[1]),
      .fall_tick    (ftk[1]),
      .period       (per1),
      .period_valid (pvl[1]),
      .stalled      (stl[1]),
      .edge_count   (ecn[1])
   );

   int  n_vec = 0;
   int  n_err = 0;
   bit  abort = 0;

   // Per-instance configuration and model state.
   int  st [2];
   int  pmax [2];
   int  tmo [2];
   bit  hist [$];
   int  since_rise [2];
   int  since_edge [2];
   bit  measuring [2];
   bit  m_stalled [2];
   bit  e_level [2];
   bit  e_rise [2];
   bit  e_fall [2];
   bit  e_pv [2];
   int  e_period [2];
   logic [7:0] e_ecnt [2];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
         if (n_err > 50) abort = 1;
      end
   endtask

   task automatic model_reset();
      hist.delete();
      repeat (8) hist.push_back(1'b0);
      for (int i = 0; i < 2; i++) begin
         since_rise[i] = 0;
         since_edge[i] = 0;
         measuring[i]  = 0;
         m_stalled[i]  = 0;
         e_level[i]    = 0;
         e_rise[i]     = 0;
         e_fall[i]     = 0;
         e_pv[i]       = 0;
         e_period[i]   = 0;
         e_ecnt[i]     = 8'd0;
      end
   endtask

   // One active clock edge: level is the input sampled st-1 edges ago, prev one edge before that.
   task automatic model_edge();
      int hn;
      bit lv, pv, r, f;
      if (rst_n) begin
         hn = hist.size();
         for (int i = 0; i < 2; i++) begin
            lv = hist[hn - st[i]];
            pv = hist[hn - st[i] - 1];
            r  = en && lv && !pv;
            f  = en && !lv && pv;
            e_rise[i] = r;
            e_fall[i] = f;
            e_pv[i]   = 0;
            if (en) begin
               if (r) begin
                  if (measuring[i]) begin
                     e_period[i] = (since_rise[i] + 1 > pmax[i]) ? pmax[i] : since_rise[i] + 1;
                     e_pv[i] = 1;
                  end
                  measuring[i]  = 1;
                  m_stalled[i]  = 0;
                  since_rise[i] = 0;
                  since_edge[i] = 0;
                  e_ecnt[i]     = e_ecnt[i] + 8'd1;
               end else begin
                  since_rise[i]++;
                  if (f) begin
                     since_edge[i] = 0;
                     m_stalled[i]  = 0;
                  end else begin
                     if (!m_stalled[i] && since_edge[i] >= tmo[i] - 1) begin
                        m_stalled[i] = 1;
                        measuring[i] = 0;
                     end
                     since_edge[i]++;
                  end
               end
            end
         end
         hist.push_back(slow_in);
         if (hist.size() > 8) void'(hist.pop_front());
         hn = hist.size();
         for (int i = 0; i < 2; i++) e_level[i] = hist[hn - st[i]];
      end
   endtask

   task automatic compare_all();
      for (int i = 0; i < 2; i++) begin
         check($sformatf("level%0d", i), 32'(lvl[i]), 32'(e_level[i]));
         check($sformatf("rise_tick%0d", i), 32'(rtk[i]), 32'(e_rise[i]));
         check($sformatf("fall_tick%0d", i), 32'(ftk[i]), 32'(e_fall[i]));
         check($sformatf("period%0d", i), (i == 0) ? 32'(per0) : 32'(per1), 32'(e_period[i]));
         check($sformatf("period_valid%0d", i), 32'(pvl[i]), 32'(e_pv[i]));
         check($sformatf("stalled%0d", i), 32'(stl[i]), 32'(m_stalled[i]));
         check($sformatf("edge_count%0d", i), 32'(ecn[i]), 32'(e_ecnt[i]));
      end
   endtask

   // Called just after a falling clock edge; returns just after the next one.
   task automatic step(input logic s, input logic e);
      if (!abort) begin
         slow_in = s;
         en      = e;
         @(posedge clk);
         model_edge();
         @(negedge clk);
         compare_all();
      end
   endtask

   task automatic run(input logic s, input int n);
      for (int c = 0; c < n; c++) step(s, 1'b1);
   endtask

   // Asynchronous reset asserted mid-cycle, held across three edges.
   task automatic mid_reset();
      if (!abort) begin
         #2 rst_n = 1'b0;
         model_reset();
         #1 compare_all();
         for (int c = 0; c < 3; c++) step(slow_in, en);
         rst_n = 1'b1;
      end
   endtask

   initial begin
      logic s;
      int   half;
      int   tog;
      st[0] = 2;  pmax[0] = 65535; tmo[0] = 2000;
      st[1] = 3;  pmax[1] = 15;    tmo[1] = 100;
      model_reset();

      // Reset with the input already high, then release.
      slow_in = 1'b1;
      #1 rst_n = 1'b0;
      @(negedge clk);
      compare_all();
      for (int c = 0; c < 3; c++) step(1'b1, 1'b1);
      rst_n = 1'b1;
      run(1'b1, 20);

      // Steady period of 1000.
      for (int p = 0; p < 4; p++) begin
         run(1'b0, 500);
         run(1'b1, 500);
      end
      check("steady_period", 32'(per0), 32'd1000);

      // Period 40: saturates the 4-bit instance.
      for (int p = 0; p < 4; p++) begin
         run(1'b0, 20);
         run(1'b1, 20);
      end
      check("sat_period_wide", 32'(per0), 32'd40);
      check("sat_period_narrow", 32'(per1), 32'd15);

      // Stall and recovery.
      run(1'b1, 2100);
      check("stall_flag", 32'(stl[0]), 32'd1);
      run(1'b0, 500);
      run(1'b1, 500);
      run(1'b0, 500);
      run(1'b1, 30);
      check("recover_period", 32'(per0), 32'd1000);

      // Enable dropped across a rising edge.
      run(1'b0, 27);
      for (int c = 0; c < 12; c++) step(1'b1, 1'b0);
      run(1'b1, 18);
      run(1'b0, 30);
      run(1'b1, 30);

      // Randomized segments with enable gaps, stalls and mid-operation resets.
      s = 1'b1;
      for (int seg = 0; seg < 30; seg++) begin
         half = (seg % 8 == 7) ? 2050 : $urandom_range(1, 150);
         tog  = (seg % 8 == 7) ? 2 : $urandom_range(2, 6);
         for (int t = 0; t < tog; t++) begin
            s = ~s;
            for (int c = 0; c < half; c++) step(s, ($urandom_range(0, 15) != 0));
            if ($urandom_range(0, 12) == 0) mid_reset();
         end
      end
      mid_reset();
      run(s, 10);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
